// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined 8-function ALU with valid/ready handshaking.
//
// Stage S1 registers the accepted operands and command. Stage S2 registers the
// computed result and flags, and drives the output port. Together the two
// stages give one operation per cycle with no bubbles, and they hold at most
// two operations under backpressure.
//
// Parameters
//   WIDTH      operand/result width in bits (2..64), default 32
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset; clears both stages
//   in_valid   an operation is offered on operand_a/operand_b/command
//   in_ready   the offered operation is accepted this cycle
//   operand_a  first operand
//   operand_b  second operand
//   command    0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
//   out_valid  result and flags are valid
//   out_ready  the consumer takes the result this cycle
//   result     operation result
//   carryout   carry out of the MSB (SUB/SLT: 1 means no borrow)
//   overflow   signed overflow (ADD/SUB/SLT only)
//   zero       result is all zeros
//
// Optional feature (macro ALU_PIPE_STICKY_OVF_EN)
//   ovf_clear  input; clears the sticky overflow flag
//   ovf_sticky output; set by any transfer-out with overflow=1, cleared by
//              ovf_clear, set wins when both happen in the same cycle
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
`ifdef ALU_PIPE_STICKY_OVF_EN
  ,
  input  logic             ovf_clear,
  output logic             ovf_sticky
`endif
);

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  // Everything S2 presents on the output port.
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
  } alu_out_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  cmd_e             s1_cmd_q,   s1_cmd_d;

  logic             s2_valid_q, s2_valid_d;
  alu_out_t         s2_q,       s2_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_adv;   // S1 content moves into S2 at the next edge
  logic accept;   // input transfer at the next edge
  logic xfer_out; // output transfer at the next edge

  always_comb begin
    xfer_out = s2_valid_q && out_ready;
    // S2 can take new content when it is empty or is emptying this cycle.
    s1_adv   = !s2_valid_q || out_ready;
    // Depends only on state and out_ready, never on in_valid.
    in_ready = !s1_valid_q || s1_adv;
    accept   = in_valid && in_ready;
  end

  // ---------------------------------------------------------------------------
  // ALU datapath, evaluated on the S1 contents
  // ---------------------------------------------------------------------------
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c_into_msb;
  logic             add_ovf;
  alu_out_t         alu_out;

  // NOTE: every signal written in an always_comb gets a value before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_sub     = (s1_cmd_q == CMD_SUB) || (s1_cmd_q == CMD_SLT);
    // Subtraction reuses the adder as A + ~B + 1.
    b_eff      = is_sub ? ~s1_b_q : s1_b_q;
    sum        = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
    // of the sum without a second adder.
    c_into_msb = sum[WIDTH-1] ^ s1_a_q[WIDTH-1] ^ b_eff[WIDTH-1];
    add_ovf    = c_into_msb ^ sum[WIDTH];

    alu_out        = '0;
    alu_out.result = sum[WIDTH-1:0];
    alu_out.carry  = sum[WIDTH];
    alu_out.ovf    = add_ovf;

    unique case (s1_cmd_q)
      CMD_ADD, CMD_SUB: begin
        alu_out.result = sum[WIDTH-1:0];
      end
      CMD_SLT: begin
        // Signed less-than: sign of A-B corrected by its overflow.
        alu_out.result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      end
      CMD_XOR: begin
        alu_out.result = s1_a_q ^ s1_b_q;
        alu_out.carry  = 1'b0;
        alu_out.ovf    = 1'b0;
      end
      CMD_AND: begin
        alu_out.result = s1_a_q & s1_b_q;
        alu_out.carry  = 1'b0;
        alu_out.ovf    = 1'b0;
      end
      CMD_NAND: begin
        alu_out.result = ~(s1_a_q & s1_b_q);
        alu_out.carry  = 1'b0;
        alu_out.ovf    = 1'b0;
      end
      CMD_NOR: begin
        alu_out.result = ~(s1_a_q | s1_b_q);
        alu_out.carry  = 1'b0;
        alu_out.ovf    = 1'b0;
      end
      CMD_OR: begin
        alu_out.result = s1_a_q | s1_b_q;
        alu_out.carry  = 1'b0;
        alu_out.ovf    = 1'b0;
      end
      default: begin
        alu_out = '0;
      end
    endcase

    alu_out.zero = (alu_out.result == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cmd_d   = s1_cmd_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;

    // S1: load on accept, otherwise empty out when its content moves on.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = operand_a;
      s1_b_d     = operand_b;
      s1_cmd_d   = cmd_e'(command);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2: take S1 when allowed; otherwise hold, keeping the outputs stable
    // while the consumer stalls.
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = alu_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      // NOTE: the S1 data flops are reset only for deterministic simulation;
      // the S2 payload must reset because it drives the output port directly
      // and must read as zero during reset.
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cmd_q   <= CMD_ADD;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cmd_q   <= s1_cmd_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

`ifdef ALU_PIPE_STICKY_OVF_EN
  // ---------------------------------------------------------------------------
  // Sticky overflow: set by an overflowing transfer-out, set beats clear.
  // ---------------------------------------------------------------------------
  logic ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (xfer_out && s2_q.ovf) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`else
  // Output transfer is only observed by the sticky flag.
  logic unused_xfer_out;
  assign unused_xfer_out = xfer_out;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = s2_valid_q;
  assign result    = s2_q.result;
  assign carryout  = s2_q.carry;
  assign overflow  = s2_q.ovf;
  assign zero      = s2_q.zero;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH = 32).
//
// Inputs change 1 time unit after a rising edge; outputs and handshakes are
// sampled on the falling edge, where they are stable for the coming edge.
// Expected values come from directed constants and from a reference model
// that evaluates each command with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [2:0]   command;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;
`ifdef ALU_PIPE_STICKY_OVF_EN
  logic         ovf_clear;
  logic         ovf_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Packed {result, carryout, overflow, zero}
  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   cmd;
    exp_t         e;
  } vec_t;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .command   (command),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero)
`ifdef ALU_PIPE_STICKY_OVF_EN
    ,
    .ovf_clear (ovf_clear),
    .ovf_sticky(ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {result, carryout, overflow, zero};
  endfunction

  // Reference model: integer arithmetic on the mathematical values.
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] cmd);
    exp_t        e;
    longint      sa, sb, s;
    longint      ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    e  = '0;
    case (cmd)
      3'd0: begin
        e.r = a + b;
        e.c = (ua + ub) >= 64'sd4294967296;
        s   = sa + sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1, 3'd3: begin
        e.r = a - b;
        e.c = (ua >= ub);
        s   = sa - sb;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (cmd == 3'd3) e.r = (sa < sb) ? 32'd1 : 32'd0;
      end
      3'd2: e.r = a ^ b;
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    corners[5] = 32'h8000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return W'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [2:0] cmd);
    in_valid  = v;
    operand_a = a;
    operand_b = b;
    command   = cmd;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 3'd0);
`ifdef ALU_PIPE_STICKY_OVF_EN
    ovf_clear = 1'b0;
`endif
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_tests++;
    if (observed() !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", observed());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
`ifdef ALU_PIPE_STICKY_OVF_EN
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL reset_sticky got %b want 0", ovf_sticky);
    end
`endif
  endtask

  // ADD overflow corner, also checking the pipeline latency.
  task automatic test_latency();
    exp_t want;
    want = {32'h8000_0000, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL lat_accept in_ready got %b want 1", in_ready);
    end
    step(); // capture edge
    drive(1'b0, '0, '0, 3'd0);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_early out_valid got %b want 0", out_valid);
    end
    step(); // result edge
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL lat_valid out_valid got %b want 1", out_valid);
    end
    n_tests++;
    if (observed() !== want) begin
      n_fail++; $display("FAIL lat_add_ovf got %h want %h", observed(), want);
    end
    step(); // transferred out
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_drain out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t tbl [11];
    tbl[0]  = {32'd5,         32'd5,         3'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = {32'd0,         32'd1,         3'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[2]  = {32'hFFFF_FFFF, 32'h0000_0001, 3'd3, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = {32'h7FFF_FFFF, 32'h8000_0000, 3'd3, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[4]  = {32'hA5A5_A5A5, 32'hFFFF_0000, 3'd2, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0};
    tbl[5]  = {32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd4, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = {32'h0000_0000, 32'h0000_0000, 3'd6, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[8]  = {32'h1234_0000, 32'h0000_5678, 3'd7, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[9]  = {32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[10] = {32'h8000_0000, 32'h8000_0000, 3'd0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cmd);
      step();
      drive(1'b0, '0, '0, 3'd0);
      step();
      n_tests++;
      if (out_valid !== 1'b1 || observed() !== tbl[i].e) begin
        n_fail++;
        $display("FAIL directed[%0d] cmd=%0d got v=%b %h want v=1 %h",
                 i, tbl[i].cmd, out_valid, observed(), tbl[i].e);
      end
      step();
    end
  endtask

  // Four ops offered back to back while the consumer stalls for 5 cycles.
  task automatic test_backpressure();
    logic [W-1:0] a [4];
    logic [W-1:0] b [4];
    logic [2:0]   c [4];
    exp_t         e [4];
    int           sent;
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_operand();
      b[i] = rand_operand();
      c[i] = 3'($urandom_range(0, 7));
      e[i] = model(a[i], b[i], c[i]);
    end
    sent = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (sent < 4) drive(1'b1, a[sent], b[sent], c[sent]);
      else          drive(1'b0, '0, '0, 3'd0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
    end
    n_tests++;
    if (sent != 2) begin
      n_fail++; $display("FAIL bp_accepts got %0d want 2", sent);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b1 || observed() !== e[0]) begin
      n_fail++; $display("FAIL bp_hold got v=%b %h want v=1 %h", out_valid, observed(), e[0]);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (sent < 4) drive(1'b1, a[sent], b[sent], c[sent]);
      else          drive(1'b0, '0, '0, 3'd0);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || observed() !== e[k]) begin
        n_fail++; $display("FAIL bp_release[%0d] got v=%b %h want v=1 %h", k, out_valid, observed(), e[k]);
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    n_tests++;
    if (sent != 4) begin
      n_fail++; $display("FAIL bp_all_accepted got %0d want 4", sent);
    end
  endtask

  // Full-rate streaming: accept and transfer-out every cycle.
  task automatic test_back_to_back();
    exp_t q[$];
    exp_t want;
    int   sent, recv;
    bit   started;
    sent = 0; recv = 0; started = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && recv < 20; cyc++) begin
      if (sent < 20) drive(1'b1, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
      else           drive(1'b0, '0, '0, 3'd0);
      @(negedge clk);
      if (sent < 20) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready cyc=%0d got %b want 1", cyc, in_ready);
        end
      end
      if (started && recv < 20) begin
        n_tests++;
        if (out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_bubble cyc=%0d out_valid got %b want 1", cyc, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        started = 1;
        want = (q.size() > 0) ? q.pop_front() : exp_t'(0);
        n_tests++;
        if (observed() !== want) begin
          n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", recv, observed(), want);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(operand_a, operand_b, command));
        sent++;
      end
      step();
    end
    n_tests++;
    if (recv != 20) begin
      n_fail++; $display("FAIL b2b_count got %0d want 20", recv);
    end
  endtask

  // Random valid/ready traffic against the scoreboard.
  task automatic test_random();
    exp_t q[$];
    exp_t want, held;
    bit   stall_prev;
    stall_prev = 0;
    held       = '0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      if (cyc < 400) begin
        drive(($urandom_range(0, 3) != 0), rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        drive(1'b0, '0, '0, 3'd0);
        out_ready = 1'b1;
        if (q.size() == 0) break;
      end
      @(negedge clk);
      n_tests++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc=%0d got %b occ=%0d out_ready=%b",
                           cyc, in_ready, q.size(), out_ready);
      end
      if (stall_prev) begin
        n_tests++;
        if (out_valid !== 1'b1 || observed() !== held) begin
          n_fail++; $display("FAIL rnd_stall_hold cyc=%0d got v=%b %h want v=1 %h",
                             cyc, out_valid, observed(), held);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious cyc=%0d got %h want nothing", cyc, observed());
        end else begin
          want = q.pop_front();
          if (observed() !== want) begin
            n_fail++; $display("FAIL rnd_data cyc=%0d got %h want %h", cyc, observed(), want);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = observed();
      if (in_valid && in_ready) q.push_back(model(operand_a, operand_b, command));
      step();
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain left %0d want 0", q.size());
    end
  endtask

  // Reset with both stages full.
  task automatic test_reset_mid();
    int sent;
    sent = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6 && sent < 2; cyc++) begin
      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      step();
    end
    drive(1'b0, '0, '0, 3'd0);
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || observed() !== exp_t'(0)) begin
      n_fail++; $display("FAIL rmid_clear got v=%b %h want v=0 0", out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_in_ready got %b want 1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rmid_stale[%0d] out_valid got %b want 0", k, out_valid);
      end
      step();
    end
  endtask

`ifdef ALU_PIPE_STICKY_OVF_EN
  // Leaves the op in S2 with out_valid=1; the next edge transfers it.
  task automatic send_to_s2(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] cmd);
    out_ready = 1'b1;
    drive(1'b1, a, b, cmd);
    step();
    drive(1'b0, '0, '0, 3'd0);
    step();
  endtask

  task automatic test_sticky();
    ovf_clear = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sticky_init got %b want 0", ovf_sticky);
    end
    send_to_s2(32'h7FFF_FFFF, 32'h1, 3'd0);
    step();
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set got %b want 1", ovf_sticky);
    end
    send_to_s2(32'h1, 32'h1, 3'd0);
    step();
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sticky_keep got %b want 1", ovf_sticky);
    end
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear got %b want 0", ovf_sticky);
    end
    send_to_s2(32'h7FFF_FFFF, 32'h1, 3'd0);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    n_tests++;
    if (ovf_sticky !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set_priority got %b want 1", ovf_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef ALU_PIPE_STICKY_OVF_EN
    test_sticky();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
